// File: rtl/cjb_bus_arb2_v.sv
`default_nettype none
// ============================================================================
// Module   : cjb_bus_arb2_v
// Purpose  : Two-requester round-robin arbiter with bounded burst ownership,
//            feeding a single-entry registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module cjb_bus_arb2_v #(
  parameter int N     = 8,  // data width
  parameter int BURST = 4   // max consecutive beats per owner (>= 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [N-1:0] d0,
  input  logic         req1,
  input  logic [N-1:0] d1,
  input  logic         out_ready,
  output logic         gnt0,
  output logic         gnt1,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         out_src
);

  localparam int            CW      = $clog2(BURST + 1);
  localparam logic [CW-1:0] c_BURST = CW'(BURST);
  localparam logic [CW-1:0] c_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_pri;
  logic          w_pri_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic          r_out_valid;
  logic [N-1:0]  r_out_data;
  logic          r_out_src;

  logic          w_space;
  logic          w_arb;
  logic          w_pri_eff;
  logic          w_gnt0;
  logic          w_gnt1;
  logic [N-1:0]  w_mux;

  // Grant decision: continue an ownership or re-arbitrate in the same cycle
  always_comb begin
    w_space     = !r_out_valid || out_ready;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    w_pri_nxt   = r_pri;
    w_cnt_nxt   = r_cnt;
    w_arb       = 1'b0;
    w_pri_eff   = r_pri;

    // With no output space everything is frozen, including ownership.
    if (!rst && w_space) begin
      case (r_state)
        S_OWN0: begin
          if (req0 && (r_cnt < c_BURST)) begin
            w_gnt0    = 1'b1;
            w_cnt_nxt = r_cnt + c_ONE;
          end else begin
            // Release (dropped request or burst exhausted): other side first.
            w_arb     = 1'b1;
            w_pri_eff = 1'b1;
          end
        end
        S_OWN1: begin
          if (req1 && (r_cnt < c_BURST)) begin
            w_gnt1    = 1'b1;
            w_cnt_nxt = r_cnt + c_ONE;
          end else begin
            w_arb     = 1'b1;
            w_pri_eff = 1'b0;
          end
        end
        default: w_arb = 1'b1;
      endcase

      if (w_arb) begin
        w_state_nxt = S_IDLE;
        w_pri_nxt   = w_pri_eff;
        w_cnt_nxt   = '0;
        if (req0 && req1) begin
          w_gnt0 = !w_pri_eff;
          w_gnt1 = w_pri_eff;
        end else begin
          w_gnt0 = req0;
          w_gnt1 = req1;
        end
        if (w_gnt0 || w_gnt1) begin
          w_cnt_nxt = c_ONE;
          if (BURST > 1) begin
            w_state_nxt = w_gnt1 ? S_OWN1 : S_OWN0;
          end else begin
            // Single-beat bursts never hold ownership; rotate immediately.
            w_pri_nxt = !w_gnt1;
          end
        end
      end
    end
  end

  // Arbiter state, priority pointer and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pri   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pri   <= w_pri_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_mux = w_gnt1 ? d1 : d0;

  // Output stage: a grant loads (even over a departing word), otherwise drain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 1'b0;
    end else if (w_gnt0 || w_gnt1) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux;
      r_out_src   <= w_gnt1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_cjb_bus_arb2_v.sv
`default_nettype none
// ============================================================================
// Module   : tb_cjb_bus_arb2_v
// Purpose  : Directed self-checking bench for cjb_bus_arb2_v (N=8, BURST=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cjb_bus_arb2_v;

  logic       clk;
  logic       rst;
  logic       req0;
  logic [7:0] d0;
  logic       req1;
  logic [7:0] d1;
  logic       out_ready;
  logic       gnt0;
  logic       gnt1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_src;

  int n_checks;
  int n_fail;

  cjb_bus_arb2_v #(.N(8), .BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .d0        (d0),
    .req1      (req1),
    .d1        (d1),
    .out_ready (out_ready),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req0      = 1'b0;
    req1      = 1'b0;
    d0        = 8'h00;
    d1        = 8'h00;
    out_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req0      = 1'b1;
    req1      = 1'b1;
    d0        = 8'h5A;
    d1        = 8'hC3;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({gnt0, gnt1} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_gnt cyc%0d: got %b required 00", i, {gnt0, gnt1});
      end
      cyc();
    end
    n_checks++;
    if ({out_valid, out_data, out_src} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h src=%b required 0/00/0",
               out_valid, out_data, out_src);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b required 10", {gnt0, gnt1});
    end
    cyc();
    n_checks++;
    if ({out_valid, out_data, out_src} !== {1'b1, 8'h5A, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_first_word: got valid=%b data=%h src=%b required 1/5a/0",
               out_valid, out_data, out_src);
    end
  endtask

  // Lone requester 0 for six beats: crosses the BURST boundary (re-grant)
  task automatic test_lone_stream();
    logic [7:0] exp_d;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      exp_d = 8'h11 + 8'(k);
      req0  = 1'b1;
      d0    = exp_d;
      #1;
      n_checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
        n_fail++;
        $display("FAIL lone_gnt beat%0d: got %b required 10", k, {gnt0, gnt1});
      end
      cyc();
      n_checks++;
      if ({out_valid, out_data, out_src} !== {1'b1, exp_d, 1'b0}) begin
        n_fail++;
        $display("FAIL lone_out beat%0d: got valid=%b data=%h src=%b required 1/%h/0",
                 k, out_valid, out_data, out_src, exp_d);
      end
    end
    req0 = 1'b0;
    cyc();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lone_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_burst_fairness();
    logic [8:0] pattern;
    logic       exp_src;
    logic [7:0] exp_d;
    pattern = 9'b0_1111_0000;  // bit i = expected winner of grant i
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      d0      = 8'h40 + 8'(i);
      d1      = 8'h80 + 8'(i);
      exp_src = pattern[i];
      exp_d   = exp_src ? d1 : d0;
      #1;
      n_checks++;
      if ({gnt0, gnt1} !== {!exp_src, exp_src}) begin
        n_fail++;
        $display("FAIL fair_gnt step%0d: got %b required %b", i, {gnt0, gnt1},
                 {!exp_src, exp_src});
      end
      cyc();
      n_checks++;
      if ({out_valid, out_data, out_src} !== {1'b1, exp_d, exp_src}) begin
        n_fail++;
        $display("FAIL fair_out step%0d: got data=%h src=%b required %h/%b",
                 i, out_data, out_src, exp_d, exp_src);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req0 = 1'b1;
    d0   = 8'hA5;
    cyc();
    req0      = 1'b0;
    out_ready = 1'b0;
    req1      = 1'b1;
    d1        = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({gnt0, gnt1} !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_no_gnt cyc%0d: got %b required 00", i, {gnt0, gnt1});
      end
      cyc();
      n_checks++;
      if ({out_valid, out_data, out_src} !== {1'b1, 8'hA5, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: got valid=%b data=%h src=%b required 1/a5/0",
                 i, out_valid, out_data, out_src);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release_gnt: got %b required 01", {gnt0, gnt1});
    end
    cyc();
    req1 = 1'b0;
    n_checks++;
    if ({out_valid, out_data, out_src} !== {1'b1, 8'h3C, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_replace: got valid=%b data=%h src=%b required 1/3c/1",
               out_valid, out_data, out_src);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req0 = 1'b1;
    d0   = 8'h01;
    cyc();
    d0 = 8'h02;
    cyc();
    // Owner 0 now holds cnt=2; drop req0 while 1 is waiting.
    req0 = 1'b0;
    req1 = 1'b1;
    d1   = 8'h77;
    #1;
    n_checks++;
    if ({gnt0, gnt1} !== 2'b01) begin
      n_fail++;
      $display("FAIL early_gnt: got %b required 01", {gnt0, gnt1});
    end
    cyc();
    n_checks++;
    if ({out_valid, out_data, out_src} !== {1'b1, 8'h77, 1'b1}) begin
      n_fail++;
      $display("FAIL early_out: got valid=%b data=%h src=%b required 1/77/1",
               out_valid, out_data, out_src);
    end
    // Fresh ownership of 1 (cnt=1) allows three more beats, then yields.
    req0 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      n_checks++;
      if ({gnt0, gnt1} !== ((j < 3) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL early_owner beat%0d: got %b required %b", j, {gnt0, gnt1},
                 (j < 3) ? 2'b01 : 2'b10);
      end
      cyc();
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_mid_burst_reset();
    do_reset();
    req1 = 1'b1;
    d1   = 8'h99;
    cyc();
    cyc();
    cyc();
    // Owner 1 at cnt=3 with a word in flight.
    rst  = 1'b1;
    req0 = 1'b1;
    d0   = 8'h66;
    #1;
    n_checks++;
    if ({gnt0, gnt1} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_rst_gnt: got %b required 00", {gnt0, gnt1});
    end
    cyc();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_valid: got %b required 0", out_valid);
    end
    #1;
    n_checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_rst_first: got %b required 10", {gnt0, gnt1});
    end
    cyc();
    n_checks++;
    if ({out_valid, out_data, out_src} !== {1'b1, 8'h66, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_rst_out: got valid=%b data=%h src=%b required 1/66/0",
               out_valid, out_data, out_src);
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_lone_stream();
    test_burst_fairness();
    test_backpressure();
    test_early_release();
    test_mid_burst_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
